tlc_phase_scheduler: RTL and testbench

//  Phase scheduler for a two-road intersection: sequences the H/V green-yellow-left lamp phases with
//  run-time programmable durations, pedestrian walk requests with early green termination, and

---
 rtl/tlc_phase_scheduler_if.sv | 11 +
 rtl/tlc_phase_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_tlc_phase_scheduler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tlc_phase_scheduler_if.sv
// Host configuration bus for the phase scheduler: one write strobe, a register select and the data.
interface tlc_phase_scheduler_if #(
    parameter int CNT_W = 5
);
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_data;

    modport master (output cfg_we, output cfg_sel, output cfg_data);
    modport slave  (input  cfg_we, input  cfg_sel, input  cfg_data);
endinterface

// File: rtl/tlc_phase_scheduler.sv
// Two-road lamp phase sequencer with programmable durations, pedestrian early termination and
// emergency preemption through an all-red clearance. States: IDLE HG HY HL VG VY VL ALLRED EMG_H EMG_V.
module tlc_phase_scheduler #(
    parameter int CNT_W      = 5,
    parameter int GREEN_DEF  = 30,
    parameter int YELLOW_DEF = 5,
    parameter int LEFT_DEF   = 10,
    parameter int MING_DEF   = 8,
    parameter int CLEAR_TIME = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    tlc_phase_scheduler_if.slave  cfg,
    input  logic                  ped_req_h,
    input  logic                  ped_req_v,
    input  logic                  emg_req,
    input  logic                  emg_dir,
    output logic                  Horizontal_Green,
    output logic                  Horizontal_Yellow,
    output logic                  Horizontal_Left,
    output logic                  Horizontal_Red,
    output logic                  Vertical_Green,
    output logic                  Vertical_Yellow,
    output logic                  Vertical_Left,
    output logic                  Vertical_Red,
    output logic                  walk_h,
    output logic                  walk_v,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HG     = 4'd1,
        S_HY     = 4'd2,
        S_HL     = 4'd3,
        S_VG     = 4'd4,
        S_VY     = 4'd5,
        S_VL     = 4'd6,
        S_ALLRED = 4'd7,
        S_EMG_H  = 4'd8,
        S_EMG_V  = 4'd9
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] act_dur;
    logic [CNT_W-1:0] act_ming;
    logic [CNT_W-1:0] green_dur;
    logic [CNT_W-1:0] yellow_dur;
    logic [CNT_W-1:0] left_dur;
    logic [CNT_W-1:0] ming_dur;
    logic [CNT_W-1:0] entry_dur;
    logic             ped_pend_h;
    logic             ped_pend_v;
    logic             from_v;
    logic             expired;
    logic             freeze;
    logic             entering;

    assign expired  = (count == act_dur);
    assign entering = (nxt != state);

    always_comb begin
        nxt    = state;
        freeze = 1'b0;
        case (state)
            S_IDLE: nxt = S_HG;
            S_HG: begin
                if (emg_req && emg_dir)
                    nxt = S_HY;
                else if (emg_req)
                    freeze = 1'b1;
                else if (expired || (ped_pend_v && (count >= act_ming)))
                    nxt = S_HY;
            end
            S_HY: if (expired) nxt = emg_req ? S_ALLRED : S_HL;
            // Own-direction emergency lets the left turn finish, then clears through yellow.
            S_HL: begin
                if (emg_req && emg_dir)
                    nxt = S_HY;
                else if (expired)
                    nxt = emg_req ? S_HY : S_VG;
            end
            S_VG: begin
                if (emg_req && !emg_dir)
                    nxt = S_VY;
                else if (emg_req)
                    freeze = 1'b1;
                else if (expired || (ped_pend_h && (count >= act_ming)))
                    nxt = S_VY;
            end
            S_VY: if (expired) nxt = emg_req ? S_ALLRED : S_VL;
            S_VL: begin
                if (emg_req && !emg_dir)
                    nxt = S_VY;
                else if (expired)
                    nxt = emg_req ? S_VY : S_HG;
            end
            S_ALLRED: begin
                if (expired) begin
                    if (emg_req)
                        nxt = emg_dir ? S_EMG_V : S_EMG_H;
                    else
                        nxt = from_v ? S_HG : S_VG;
                end
            end
            S_EMG_H: begin
                if (!emg_req || emg_dir)
                    nxt = S_HY;
                else
                    freeze = 1'b1;
            end
            S_EMG_V: begin
                if (!emg_req || !emg_dir)
                    nxt = S_VY;
                else
                    freeze = 1'b1;
            end
            default: nxt = S_HG;
        endcase
    end

    always_comb begin
        entry_dur = '0;
        case (nxt)
            S_HG, S_VG: entry_dur = green_dur;
            S_HY, S_VY: entry_dur = yellow_dur;
            S_HL, S_VL: entry_dur = left_dur;
            S_ALLRED:   entry_dur = CNT_W'(CLEAR_TIME);
            default:    entry_dur = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            act_dur    <= '0;
            act_ming   <= '0;
            green_dur  <= CNT_W'(GREEN_DEF);
            yellow_dur <= CNT_W'(YELLOW_DEF);
            left_dur   <= CNT_W'(LEFT_DEF);
            ming_dur   <= CNT_W'(MING_DEF);
            ped_pend_h <= 1'b0;
            ped_pend_v <= 1'b0;
            from_v     <= 1'b0;
            walk_h     <= 1'b0;
            walk_v     <= 1'b0;
        end else begin
            state <= nxt;
            // Durations latch on entry so a mid-phase write only shapes later phases.
            if (entering) begin
                count    <= '0;
                act_dur  <= entry_dur;
                act_ming <= ming_dur;
            end else if (!freeze && (count != {CNT_W{1'b1}})) begin
                count <= count + 1'b1;
            end

            if (nxt == S_ALLRED && state != S_ALLRED)
                from_v <= (state == S_VY);

            walk_h <= (nxt == S_HG) && ((state != S_HG) ? ped_pend_h : walk_h);
            walk_v <= (nxt == S_VG) && ((state != S_VG) ? ped_pend_v : walk_v);

            // A request arriving on the entry edge survives for the next green.
            ped_pend_h <= (((nxt == S_HG) && (state != S_HG)) ? 1'b0 : ped_pend_h) | ped_req_h;
            ped_pend_v <= (((nxt == S_VG) && (state != S_VG)) ? 1'b0 : ped_pend_v) | ped_req_v;

            if (cfg.cfg_we) begin
                case (cfg.cfg_sel)
                    2'd0: green_dur  <= cfg.cfg_data;
                    2'd1: yellow_dur <= cfg.cfg_data;
                    2'd2: left_dur   <= cfg.cfg_data;
                    default: ming_dur <= cfg.cfg_data;
                endcase
            end
        end
    end

    always_comb begin
        Horizontal_Green  = 1'b0;
        Horizontal_Yellow = 1'b0;
        Horizontal_Left   = 1'b0;
        Horizontal_Red    = 1'b0;
        Vertical_Green    = 1'b0;
        Vertical_Yellow   = 1'b0;
        Vertical_Left     = 1'b0;
        Vertical_Red      = 1'b0;
        case (state)
            S_HG, S_EMG_H: begin Horizontal_Green  = 1'b1; Vertical_Red   = 1'b1; end
            S_HY:          begin Horizontal_Yellow = 1'b1; Vertical_Red   = 1'b1; end
            S_HL:          begin Horizontal_Left   = 1'b1; Vertical_Red   = 1'b1; end
            S_VG, S_EMG_V: begin Vertical_Green    = 1'b1; Horizontal_Red = 1'b1; end
            S_VY:          begin Vertical_Yellow   = 1'b1; Horizontal_Red = 1'b1; end
            S_VL:          begin Vertical_Left     = 1'b1; Horizontal_Red = 1'b1; end
            S_ALLRED:      begin Horizontal_Red    = 1'b1; Vertical_Red   = 1'b1; end
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler: phase run-length tables plus hand-built preemption,
// pedestrian, config-timing and reset sequences.
module tb_tlc_phase_scheduler;

    localparam logic [3:0] IDLE = 4'd0, HG = 4'd1, HY = 4'd2, HL = 4'd3, VG = 4'd4,
                           VY = 4'd5, VL = 4'd6, AR = 4'd7, EH = 4'd8, EV = 4'd9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ped_req_h = 1'b0, ped_req_v = 1'b0, emg_req = 1'b0, emg_dir = 1'b0;
    logic hg, hy, hl, hr, vg, vy, vl, vr, walk_h, walk_v;
    logic [3:0] state_o;
    wire  [7:0] lamps = {hg, hy, hl, hr, vg, vy, vl, vr};

    int checks = 0;
    int errors = 0;
    int tnum   = 0;

    tlc_phase_scheduler_if #(.CNT_W(5)) cfg_bus ();

    tlc_phase_scheduler dut (
        .clk(clk), .reset(reset), .cfg(cfg_bus),
        .ped_req_h(ped_req_h), .ped_req_v(ped_req_v), .emg_req(emg_req), .emg_dir(emg_dir),
        .Horizontal_Green(hg), .Horizontal_Yellow(hy), .Horizontal_Left(hl), .Horizontal_Red(hr),
        .Vertical_Green(vg), .Vertical_Yellow(vy), .Vertical_Left(vl), .Vertical_Red(vr),
        .walk_h(walk_h), .walk_v(walk_v), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        int         len;
        logic       wh;
        logic       wv;
    } phase_t;

    phase_t vec [7];

    function automatic logic [7:0] lamp_exp(input logic [3:0] s);
        case (s)
            HG, EH:  return 8'b1000_0001;
            HY:      return 8'b0100_0001;
            HL:      return 8'b0010_0001;
            VG, EV:  return 8'b0001_1000;
            VY:      return 8'b0001_0100;
            VL:      return 8'b0001_0010;
            AR:      return 8'b0001_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL t%0d %s: got %0d expected %0d", tnum, nm, act, exp);
        end
    endtask

    // Expects n consecutive cycles in state st with the given walk lamps.
    task automatic hold(input logic [3:0] st, input int n, input logic wh, input logic wv);
        int bad_st = 0, bad_l = 0, bad_w = 0;
        int first = st;
        for (int i = 0; i < n; i++) begin
            if (state_o !== st) begin
                if (bad_st == 0) first = int'(state_o);
                bad_st++;
            end
            if (lamps !== lamp_exp(st)) bad_l++;
            if ({walk_h, walk_v} !== {wh, wv}) bad_w++;
            @(negedge clk);
        end
        check($sformatf("state%0d held (first seen %0d) bad cycles", st, first), bad_st, 0);
        check($sformatf("state%0d lamp bad cycles", st), bad_l, 0);
        check($sformatf("state%0d walk bad cycles", st), bad_w, 0);
    endtask

    task automatic run_phase(input logic [3:0] st, input int n, input logic wh, input logic wv);
        hold(st, n, wh, wv);
        check($sformatf("state%0d left after %0d cycles (now %0d)", st, n, state_o),
              int'(state_o !== st), 1);
    endtask

    // Walks the default ring starting at ring position s (0 = HG) for n phases.
    task automatic run_ring(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            int r = 1 + ((s + k) % 6);
            run_phase(vec[r].st, vec[r].len, vec[r].wh, vec[r].wv);
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [4:0] data);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_sel  = sel;
        cfg_bus.cfg_data = data;
    endtask

    initial begin
        vec[0] = '{IDLE, 1,  1'b0, 1'b0};
        vec[1] = '{HG,   31, 1'b0, 1'b0};
        vec[2] = '{HY,   6,  1'b0, 1'b0};
        vec[3] = '{HL,   11, 1'b0, 1'b0};
        vec[4] = '{VG,   31, 1'b0, 1'b0};
        vec[5] = '{VY,   6,  1'b0, 1'b0};
        vec[6] = '{VL,   11, 1'b0, 1'b0};
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_sel = 2'd0; cfg_bus.cfg_data = 5'd0;

        // Reset state and the default ring.
        @(negedge clk);
        hold(IDLE, 2, 1'b0, 1'b0);
        reset = 1'b0;
        tnum = 1;
        for (int i = 0; i < 7; i++) run_phase(vec[i].st, vec[i].len, vec[i].wh, vec[i].wv);
        run_ring(0, 3);

        // Pedestrian H request cuts VG at min_green, next HG shows walk_h throughout.
        tnum = 2;
        hold(VG, 3, 1'b0, 1'b0);
        ped_req_h = 1'b1;
        hold(VG, 1, 1'b0, 1'b0);
        ped_req_h = 1'b0;
        run_phase(VG, 5, 1'b0, 1'b0);
        run_phase(VY, 6, 1'b0, 1'b0);
        run_phase(VL, 11, 1'b0, 1'b0);
        run_phase(HG, 31, 1'b1, 1'b0);
        run_ring(1, 5);

        // Mid-phase green write only shapes later phases; a write on the entry edge is too late.
        tnum = 4;
        hold(HG, 5, 1'b0, 1'b0);
        cfg_write(2'd0, 5'd3);
        hold(HG, 1, 1'b0, 1'b0);
        cfg_bus.cfg_we = 1'b0;
        run_phase(HG, 25, 1'b0, 1'b0);
        run_phase(HY, 6, 1'b0, 1'b0);
        run_phase(HL, 11, 1'b0, 1'b0);
        run_phase(VG, 4, 1'b0, 1'b0);
        run_phase(VY, 6, 1'b0, 1'b0);
        run_phase(VL, 11, 1'b0, 1'b0);
        run_phase(HG, 4, 1'b0, 1'b0);
        run_phase(HY, 6, 1'b0, 1'b0);
        hold(HL, 10, 1'b0, 1'b0);
        cfg_write(2'd0, 5'd30);
        run_phase(HL, 1, 1'b0, 1'b0);
        cfg_bus.cfg_we = 1'b0;
        run_phase(VG, 4, 1'b0, 1'b0);
        run_phase(VY, 6, 1'b0, 1'b0);
        run_phase(VL, 11, 1'b0, 1'b0);
        run_phase(HG, 31, 1'b0, 1'b0);
        run_ring(1, 5);

        // Vertical preemption from HG, release back into the vertical ring.
        tnum = 3;
        hold(HG, 10, 1'b0, 1'b0);
        emg_req = 1'b1; emg_dir = 1'b1;
        run_phase(HG, 1, 1'b0, 1'b0);
        run_phase(HY, 6, 1'b0, 1'b0);
        run_phase(AR, 3, 1'b0, 1'b0);
        hold(EV, 5, 1'b0, 1'b0);
        emg_req = 1'b0;
        run_phase(EV, 1, 1'b0, 1'b0);
        run_phase(VY, 6, 1'b0, 1'b0);
        run_phase(VL, 11, 1'b0, 1'b0);
        run_phase(HG, 31, 1'b0, 1'b0);
        run_ring(1, 5);

        // Own-direction preemption freezes HG; timing resumes from the frozen count.
        tnum = 5;
        hold(HG, 7, 1'b0, 1'b0);
        emg_req = 1'b1; emg_dir = 1'b0;
        hold(HG, 50, 1'b0, 1'b0);
        emg_req = 1'b0;
        run_phase(HG, 24, 1'b0, 1'b0);

        // Emergency dropped during all-red, VG preempted, EMG_H direction flip.
        tnum = 7;
        emg_req = 1'b1; emg_dir = 1'b0;
        run_phase(HY, 6, 1'b0, 1'b0);
        hold(AR, 2, 1'b0, 1'b0);
        emg_req = 1'b0;
        run_phase(AR, 1, 1'b0, 1'b0);
        hold(VG, 3, 1'b0, 1'b0);
        emg_req = 1'b1; emg_dir = 1'b0;
        run_phase(VG, 1, 1'b0, 1'b0);
        run_phase(VY, 6, 1'b0, 1'b0);
        run_phase(AR, 3, 1'b0, 1'b0);
        hold(EH, 4, 1'b0, 1'b0);
        emg_dir = 1'b1;
        run_phase(EH, 1, 1'b0, 1'b0);
        run_phase(HY, 6, 1'b0, 1'b0);
        run_phase(AR, 3, 1'b0, 1'b0);
        hold(EV, 2, 1'b0, 1'b0);

        // Reset in EMG_V with a pending H request: request is lost, VG runs full length.
        tnum = 6;
        ped_req_h = 1'b1;
        hold(EV, 1, 1'b0, 1'b0);
        ped_req_h = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        emg_req = 1'b0;
        run_phase(IDLE, 1, 1'b0, 1'b0);
        run_ring(0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
